// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the serial FIR controller.
package fir_pkg;

  // Controller sequencing: wait for a sample, run the taps, present the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_e;

  localparam int FIR_DW   = 32;
  localparam int FIR_CW   = 16;
  localparam int FIR_TAPS = 8;

  // Full-precision accumulator width: one product plus log2(TAPS) growth bits.
  function automatic int fir_acc_width(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Single multiply-accumulate unit shared across all taps.
// term_o exposes the zero-extended product so the controller can capture the
// final sum on the same edge the accumulator absorbs the last tap.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DW   = FIR_DW,
  parameter int CW   = FIR_CW,
  parameter int ACCW = fir_acc_width(FIR_DW, FIR_CW, FIR_TAPS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic [DW-1:0]   sample_i,
  input  logic [CW-1:0]   coef_i,
  output logic [ACCW-1:0] acc_o,
  output logic [ACCW-1:0] term_o
);

  logic [DW+CW-1:0] prod_s;
  logic [ACCW-1:0]  term_s;
  logic [ACCW-1:0]  acc_d;
  logic [ACCW-1:0]  acc_q;

  // Unsigned full-width product, widened to the accumulator size.
  always_comb begin
    prod_s = {{CW{1'b0}}, sample_i} * {{DW{1'b0}}, coef_i};
    term_s = {{(ACCW-DW-CW){1'b0}}, prod_s};
  end

  // Clear takes priority so a new pass never inherits the previous sum.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = {ACCW{1'b0}};
    end else if (en_i) begin
      acc_d = acc_q + term_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {ACCW{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o  = acc_q;
  assign term_o = term_s;

endmodule

// File: rtl/fir_mac_ctrl.sv
// Time-multiplexed FIR controller: circular delay line, coefficient file,
// tap sequencer and result hand-off around one shared MAC.
module fir_mac_ctrl
  import fir_pkg::*;
#(
  parameter int DW   = FIR_DW,
  parameter int CW   = FIR_CW,
  parameter int TAPS = FIR_TAPS,
  parameter int AW   = $clog2(TAPS),
  parameter int ACCW = fir_acc_width(DW, CW, TAPS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            coef_we,
  input  logic [AW-1:0]   coef_addr,
  input  logic [CW-1:0]   coef_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_data,
  output logic            busy
);

  fir_state_e      state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   k_q, k_d;
  logic [DW-1:0]   dly_q [TAPS];
  logic [DW-1:0]   dly_d [TAPS];
  logic [CW-1:0]   coef_q [TAPS];
  logic [CW-1:0]   coef_d [TAPS];
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic [ACCW-1:0] out_data_q, out_data_d;

  logic            accept_s;
  logic            last_s;
  logic            mac_en_s;
  logic            coef_wr_s;
  logic [AW-1:0]   rd_idx_s;
  logic [DW-1:0]   sample_s;
  logic [CW-1:0]   coef_s;
  logic [ACCW-1:0] acc_s;
  logic [ACCW-1:0] term_s;

  // Handshake and sequencing decodes; the tap address walks backwards from head.
  always_comb begin
    accept_s  = (state_q == ST_IDLE) && in_valid;
    mac_en_s  = (state_q == ST_MAC);
    last_s    = (state_q == ST_MAC) && (k_q == AW'(TAPS - 1));
    coef_wr_s = coef_we && !busy_q;
    rd_idx_s  = head_q - k_q;
    sample_s  = dly_q[rd_idx_s];
    coef_s    = coef_q[k_q];
  end

  // Next state: one sample in, TAPS accumulations, then wait for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_MAC;
        else          state_d = ST_IDLE;
      end
      ST_MAC: begin
        if (last_s) state_d = ST_DONE;
        else        state_d = ST_MAC;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decodes are taken from the next state so the flops line up with it;
  // the result is captured exactly once, on the edge that enters DONE.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    if (last_s) begin
      out_data_d = acc_s + term_s;
    end else begin
      out_data_d = out_data_q;
    end
  end

  // Delay line write, head capture and tap counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    head_d   = head_q;
    k_d      = k_q;
    dly_d    = dly_q;
    if (accept_s) begin
      dly_d[wr_ptr_q] = in_data;
      head_d          = wr_ptr_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      k_d             = {AW{1'b0}};
    end else if (mac_en_s) begin
      k_d = k_q + AW'(1);
    end else begin
      k_d = k_q;
    end
  end

  // Host coefficient writes are ignored while a pass is in flight.
  always_comb begin
    coef_d = coef_q;
    if (coef_wr_s) begin
      coef_d[coef_addr] = coef_data;
    end else begin
      coef_d = coef_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= {ACCW{1'b0}};
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  // Pointers, tap counter, delay line and coefficient file; reset clears history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      head_q   <= {AW{1'b0}};
      k_q      <= {AW{1'b0}};
      for (int i = 0; i < TAPS; i++) begin
        dly_q[i]  <= {DW{1'b0}};
        coef_q[i] <= {CW{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      head_q   <= head_d;
      k_q      <= k_d;
      dly_q    <= dly_d;
      coef_q   <= coef_d;
    end
  end

  fir_mac #(
    .DW   (DW),
    .CW   (CW),
    .ACCW (ACCW)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (accept_s),
    .en_i     (mac_en_s),
    .sample_i (sample_s),
    .coef_i   (coef_s),
    .acc_o    (acc_s),
    .term_o   (term_s)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Self-checking bench for fir_mac_ctrl against a sum-of-products model
// kept as a sample history queue and a coefficient array.
module tb_fir_mac_ctrl;

  localparam int TAPS = 8;
  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int AW   = 3;
  localparam int ACCW = 51;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            coef_we;
  logic [AW-1:0]   coef_addr;
  logic [CW-1:0]   coef_data;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_data;
  logic            busy;

  logic [DW-1:0] hist [$];
  logic [CW-1:0] coef_m [TAPS];
  logic [63:0]   last_out;
  logic [63:0]   dut_last;
  bit            pend_on;
  logic [DW-1:0] pend_x;
  int            n_checks;
  int            n_errors;

  fir_mac_ctrl #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop if something hangs.
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // y[n] = sum c[k]*x[n-k], with history before the first sample taken as zero.
  function automatic logic [63:0] model_y();
    logic [63:0] s;
    int n;
    s = 64'd0;
    n = hist.size() - 1;
    for (int k = 0; k < TAPS; k++) begin
      if (n - k >= 0) s += 64'(coef_m[k]) * 64'(hist[n - k]);
    end
    return s;
  endfunction

  task automatic clear_model();
    hist.delete();
    for (int k = 0; k < TAPS; k++) coef_m[k] = 16'd0;
    last_out = 64'd0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    pend_on   = 1'b0;
    rst_n     = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 16'h1234;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    coef_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_model();
  endtask

  task automatic write_coef(input int a, input logic [CW-1:0] d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
    coef_m[a] = d;
  endtask

  // One sample through the engine; hold>0 stalls the consumer for that many
  // DONE cycles, mac_wr attempts a coefficient write mid-pass.
  task automatic send(input logic [DW-1:0] x, input int hold, input bit mac_wr);
    int n;
    logic [63:0] exp_v;
    in_valid = 1'b1;
    in_data  = x;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_delay", 64'(n), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    hist.push_back(x);
    exp_v = model_y();
    if (hold > 0) out_ready = 1'b0;
    chk("mac_busy", 64'(busy), 64'd1);
    chk("mac_in_ready", 64'(in_ready), 64'd0);
    for (int i = 1; i < TAPS; i++) begin
      if (mac_wr && i == 2) begin
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'd100;
      end else begin
        coef_we = 1'b0;
      end
      @(posedge clk); #1;
    end
    coef_we = 1'b0;
    chk("early_valid", 64'(out_valid), 64'd0);
    chk("mac_out_hold", 64'(out_data), last_out);
    @(posedge clk); #1;
    chk("done_valid", 64'(out_valid), 64'd1);
    chk("done_data", 64'(out_data), exp_v);
    chk("done_in_ready", 64'(in_ready), 64'd0);
    dut_last = 64'(out_data);
    last_out = exp_v;
    for (int i = 0; i < hold; i++) begin
      in_valid = pend_on;
      in_data  = pend_x;
      @(posedge clk); #1;
      chk("bp_data", 64'(out_data), exp_v);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int imp_exp [9];
    logic [DW-1:0] x, nx;
    int h;
    n_checks = 0;
    n_errors = 0;
    imp_exp = '{1, 2, 3, 4, 5, 6, 7, 8, 0};

    // Reset state and a coefficient write issued during reset.
    do_reset();
    send(32'd5, 0, 1'b0);
    chk("rst_coef_dropped", dut_last, 64'd0);

    // Impulse response.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, CW'(k + 1));
    for (int i = 0; i < 9; i++) begin
      send((i == 0) ? 32'd1 : 32'd0, 0, 1'b0);
      chk("impulse", dut_last, 64'(imp_exp[i]));
    end

    // Moving window with pointer wrap.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'd1);
    for (int i = 1; i <= 12; i++) send(DW'(i * 10), 0, 1'b0);
    chk("wrap680", dut_last, 64'd680);

    // Backpressure with a sample waiting.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'd1);
    send(32'd1, 0, 1'b0);
    pend_on = 1'b1;
    pend_x  = 32'd9;
    send(32'd3, 5, 1'b0);
    pend_on = 1'b0;
    send(32'd9, 0, 1'b0);
    chk("bp_sum", dut_last, 64'd13);

    // Coefficient lockout during MAC.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'd2);
    for (int i = 0; i < 8; i++) send(32'd5, 0, 1'b0);
    send(32'd5, 0, 1'b1);
    chk("lockout80", dut_last, 64'd80);
    write_coef(0, 16'd100);
    send(32'd5, 0, 1'b0);
    chk("idle_wr570", dut_last, 64'd570);

    // Randomized coefficients, samples and stalls.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, CW'($urandom));
    x = $urandom;
    for (int i = 0; i < 14; i++) begin
      h = $urandom_range(0, 2);
      nx = $urandom;
      pend_on = (h > 0);
      pend_x  = nx;
      send(x, h, 1'b0);
      x = nx;
    end
    pend_on = 1'b0;

    // Full-scale operands.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'hFFFF);
    for (int i = 0; i < 8; i++) send(32'hFFFF_FFFF, 0, 1'b0);
    chk("max_value", dut_last, 64'h7FFF7FFF80008);

    // Reset in the middle of a pass.
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    repeat (TAPS + 2) begin
      @(posedge clk); #1;
    end
    chk("midrst_no_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 9; i++) begin
      send((i == 0) ? 32'd1 : 32'd0, 0, 1'b0);
      chk("post_rst_zero", dut_last, 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_ctrl.md
# fir_mac_ctrl

Serial (time-multiplexed) FIR engine controller: accepts one input sample per valid/ready handshake, stores it in a circular delay line, and sequences a single multiply-accumulate unit over all taps to produce one full-precision output per sample. It replaces the fully parallel FIR datapath where area matters. It sits between the sample source and the result consumer, with a side port for loading coefficients from the host.

## Interface
- `DW`, 32, sample width (unsigned)
- `CW`, 16, coefficient width (unsigned)
- `TAPS`, 8, number of taps; power of two, 2..64
- `AW`, $clog2(TAPS), tap index width (derived)
- `ACCW`, DW+CW+AW, output/accumulator width (derived)
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  sample offered
- `in_ready`  out  1  controller can accept a sample
- `in_data`  in  DW  sample value
- `coef_we`  in  1  coefficient write strobe
- `coef_addr`  in  AW  tap index k
- `coef_data`  in  CW  value for c[k]
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes the result
- `out_data`  out  ACCW  y[n]
- `busy`  out  1  high in MAC and DONE

## Operation
- Computes y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k]. All arithmetic is unsigned and full precision, with no truncation or saturation.
- FSM states are IDLE, MAC and DONE.
- IDLE: `in_ready`=1. On `in_valid&&in_ready`:
  - write `buf[wr_ptr] <= in_data`
  - latch `head <= wr_ptr`
  - `wr_ptr <= wr_ptr+1` (mod TAPS, wraps naturally)
  - clear acc, set k=0, go to MAC
- MAC: each cycle does `acc += c[k]*buf[(head-k) mod TAPS]`, then `k++`. After the k=TAPS-1 accumulation, go to DONE.
- DONE: `out_valid`=1 and `out_data`=acc, held stable. On `out_ready`, go to IDLE. No new sample is accepted in DONE.
- Coefficient writes (`c[coef_addr] <= coef_data`) take effect only when `busy`=0. When `busy`=1 they are silently dropped.
- A write and a sample accept in the same IDLE cycle are both performed. The new coefficient is used by that sample's MAC pass.
- History prior to the first TAPS samples is zero (buffer reset value).

## Timing
- Reset values:
  - outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0
  - internal: all c[k]=0, all buf entries 0, `wr_ptr`=0, acc=0, state IDLE
- Reset asserted mid-MAC or mid-DONE forces the above immediately. The in-flight result is discarded, and buffer and coefficients are cleared.
- Latency: accept edge E0, then MAC on edges E1..E_TAPS. `out_valid` is high from E_TAPS onward, i.e. TAPS cycles after acceptance.
- Throughput: with `out_ready` tied high, one sample every TAPS+2 cycles.
- `out_data` changes only when entering DONE, and holds until the next DONE.
- `in_ready` is a registered decode of state. It is never combinationally dependent on `in_valid` or `out_ready`.

## Structure
- Package `fir_pkg`:
  - state enum (IDLE, MAC, DONE)
  - default DW/CW/TAPS constants
  - ACCW derivation function
- Sub-module `fir_mac`:
  - inputs: clear, enable, sample, coefficient
  - output: registered ACCW accumulator
- Controller top contains the FSM, tap counter, `wr_ptr`/`head`, buffer and coefficient register file.

## Test plan
- Reset: hold `rst_n`=0. Expect `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0. A `coef_we` issued during reset has no effect.
- Impulse: load c[k]=k+1 (1..8), then send 1,0,0,0,0,0,0,0,0. Outputs are 1,2,3,4,5,6,7,8,0, each appearing exactly 8 cycles after its accept edge.
- Window sum / wrap: load all c=1, then send 10,20,…,120 (12 samples). The 12th output is 50+60+…+120 = 680, which checks `wr_ptr` wrap.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE with `in_valid`=1. Expect `out_data` stable, `in_ready`=0 and no sample consumed. Raise `out_ready`; the pending sample is accepted 1 cycle after returning to IDLE.
- Coefficient lockout: set all c=2 and feed x=5 repeatedly. After 8 samples, write c[0]=100 during MAC; the result is still 80. Repeat the write in IDLE; the next result is 100*5+7*2*5 = 570.
- Max values / reset mid-run:
  - all c=0xFFFF, x=0xFFFFFFFF for 8 samples: output 0x7FFF7FFF80008 with no overflow
  - then pulse `rst_n` during MAC: `out_valid` stays 0, and the next impulse test reproduces all-zero outputs until coefficients are reloaded
